score_renderer: RTL and testbench
=================================

# score_renderer

Multi-digit score renderer for the Pong video path. It samples a binary score once per frame and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It then draws DIGITS scaled 4×6 glyphs side by side, with optional leading-zero blanking, overflow saturation and a blink mode. It sits beside the paddle/ball renderers, and its pixel_on is ORed into the colour mux.

## Interface
- DIGITS, 2: number of decimal digits drawn (1–4).
- SCORE_W, 7: width of binary score input (1–14).
- SCALE, 8: pixels per glyph bit; glyph is 4·SCALE × 6·SCALE.
- GAP, 8: blank pixels between adjacent digits.
- LZ_BLANK, 1: 1 = suppress leading zeros; least-significant digit always drawn.
- clk_0  in  1  25.175 MHz pixel clock.
- rst  in  1  reset, synchronous, active-low.
- pixel_x, pixel_y  in  10  current beam position.
- x_pos, y_pos  in  10  top-left corner of most-significant digit.
- score  in  SCORE_W  unsigned binary score.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- blink_en  in  1  1 = blink the whole score.
- pixel_on  out  1  registered; 1 = current pixel belongs to a lit glyph bit.
- busy  out  1  1 while a conversion is in progress.

## Operation
- FSM states:
  - IDLE: frame_start=1 loads score into shift register, clears BCD accumulator and bit counter, goes to SHIFT.
  - SHIFT: each cycle adds 3 to every BCD nibble ≥5, then shifts {BCD, bin} left one bit. After SCORE_W shifts, goes to DONE.
  - DONE: commits to the display register, increments blink counter, returns to IDLE.
- BCD accumulator holds enough nibbles for 2^SCORE_W−1.
- Saturation: if any nibble at position ≥ DIGITS is non-zero, all DIGITS display nibbles are set to 9.
- Display register updates atomically in DONE only; the old value is shown throughout conversion.
- frame_start outside IDLE is ignored. score changes during SHIFT do not affect the result.
- Digit k (0 = MSD, leftmost):
  - x in [x_pos + k·(4·SCALE+GAP), same + 4·SCALE − 1]
  - y in [y_pos, y_pos + 6·SCALE − 1]
  - Bounds are computed in 11 bits, so x_pos/y_pos near 1023 must not wrap.
- Within a digit:
  - col = rel_x / SCALE, row = rel_y / SCALE.
  - Lit bit = glyph[row][3−col]; MSB is the leftmost column.
  - Gap pixels and pixels outside all digit boxes are off.
- Glyph rows 0..5 (hex, MSB left):
  - 0: F,9,9,9,9,F
  - 1: 1,1,1,1,1,1
  - 2: F,1,F,8,8,F
  - 3: F,1,F,1,1,F
  - 4: 9,9,F,1,1,1
  - 5: F,8,F,1,1,F
  - 6: F,8,F,9,9,F
  - 7: F,1,1,1,1,1
  - 8: F,9,F,9,9,F
  - 9: F,9,F,1,1,1
  - Nibbles 10–15 render blank.
- Leading-zero blanking (LZ_BLANK=1): digit k is blank if it and all digits left of it are 0, for k < DIGITS−1.
- Blink: 6-bit frame counter. When blink_en=1 and counter[5]=1, pixel_on is forced 0 (32 frames off / 32 frames on). The counter runs regardless of blink_en.

## Timing
- Reset outputs:
  - pixel_on=0, busy=0.
  - FSM=IDLE, display register=all 0 (renders a single "0" with blanking), blink counter=0.
- Reset mid-conversion aborts it; the display register is cleared, not committed.
- Conversion: frame_start high in cycle T → busy=1 in cycles T+1 … T+SCORE_W+1.
  - New value is visible to the pixel pipe from T+SCORE_W+2.
  - busy=0 at T+SCORE_W+2.
- Pixel pipeline, 2 stages:
  - Stage 1 registers digit index, in-box flag, row and col.
  - Stage 2 registers pixel_on.
  - pixel_on at cycle t reflects pixel_x/pixel_y sampled at t−2.
  - The caller compensates by delaying sync/colour by 2.
- Pipeline runs continuously, including during busy; it uses the display register as seen in stage 2.

## Test plan
- Reset, then scan one frame with DIGITS=2, x_pos=100, y_pos=20 → only box x 140..171, y 20..67 lights, showing "0"; busy=0; pixel_on=0 during reset.
- score=42, frame_start → busy high exactly 8 cycles (SCORE_W=7). Then:
  - Pixel (100,36) (digit 0, row 2 = F) → pixel_on=1 two cycles later.
  - Pixel (108,60) (row 5 = 1, col 1) → 0.
  - Gap pixel (135,30) → 0.
- score=7 with LZ_BLANK=1 → box x 100..131 fully off; pixel (164,20) (digit 1, row 0, col 3) → 1. Same stimulus with LZ_BLANK=0 → leftmost digit draws "0".
- SCORE_W=8, score=150 → display "99". score=99 → "99". score=100 → "99".
- Pulse frame_start during SHIFT and change score mid-conversion → second pulse ignored; committed value equals score at first pulse; old digits are shown until commit.
- blink_en=1 across 64 frame_start pulses → pixel_on suppressed on frames 32–63. Assert rst mid-SHIFT → busy=0 next cycle and display is "0".

Source files
------------

// File: rtl/score_renderer.sv
// rtl/score_renderer.sv - per-frame binary-to-BCD score conversion and scaled glyph renderer
module score_renderer #(
    parameter int DIGITS   = 2,
    parameter int SCORE_W  = 7,
    parameter int SCALE    = 8,
    parameter int GAP      = 8,
    parameter int LZ_BLANK = 1
) (
    input  logic               clk_0,
    input  logic               rst,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic [9:0]         x_pos,
    input  logic [9:0]         y_pos,
    input  logic [SCORE_W-1:0] score,
    input  logic               frame_start,
    input  logic               blink_en,
    output logic               pixel_on,
    output logic               busy
);

    // Number of decimal digits needed to hold 2^w - 1.
    function automatic int dec_digits(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (v > 0) begin
                v = v / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    localparam int NIB_RAW = dec_digits(SCORE_W);
    // The accumulator always covers the displayed digits, even for narrow scores.
    localparam int NIB     = (NIB_RAW > DIGITS) ? NIB_RAW : DIGITS;
    localparam int BW      = 4 * NIB;
    localparam int BOX_W   = 4 * SCALE;
    localparam int BOX_H   = 6 * SCALE;
    localparam int PITCH   = BOX_W + GAP;

    // Glyph row r of decimal digit d, MSB is the leftmost column; 10..15 are blank.
    function automatic logic [3:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
        logic [23:0] g;
        logic [3:0]  row;
        case (d)
            4'd0:    g = 24'hF9999F;
            4'd1:    g = 24'h111111;
            4'd2:    g = 24'hF1F88F;
            4'd3:    g = 24'hF1F11F;
            4'd4:    g = 24'h99F111;
            4'd5:    g = 24'hF8F11F;
            4'd6:    g = 24'hF8F99F;
            4'd7:    g = 24'hF11111;
            4'd8:    g = 24'hF9F99F;
            4'd9:    g = 24'hF9F111;
            default: g = 24'h000000;
        endcase
        case (r)
            3'd0:    row = g[23:20];
            3'd1:    row = g[19:16];
            3'd2:    row = g[15:12];
            3'd3:    row = g[11:8];
            3'd4:    row = g[7:4];
            3'd5:    row = g[3:0];
            default: row = 4'h0;
        endcase
        return row;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [SCORE_W-1:0]  bin_q;
    logic [BW-1:0]       bcd_q;
    logic [BW-1:0]       bcd_adj;
    logic [3:0]          cnt_q;
    logic [DIGITS*4-1:0] disp_q;
    logic [DIGITS*4-1:0] disp_next;
    logic                sat;
    logic [5:0]          blink_q;

    logic [10:0]         left_k;
    logic [10:0]         rel_x;
    logic [10:0]         rel_y;
    logic                y_in;
    logic                hit_d;
    logic [1:0]          dig_d;
    logic [2:0]          row_d;
    logic [1:0]          col_d;
    logic                s1_in;
    logic [1:0]          s1_dig;
    logic [2:0]          s1_row;
    logic [1:0]          s1_col;

    logic [3:0]          cur_nib;
    logic                cur_blank;
    logic                lz_run;
    logic [3:0]          grow;
    logic                pix_d;

    assign busy = (state_q != S_IDLE);

    // Conversion FSM state register.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Conversion FSM next state: one shift per score bit, then a commit cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == 4'(SCORE_W - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Add 3 to every BCD nibble of 5 or more before the next shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NIB; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Any significant nibble beyond the displayed digits saturates the display to all nines.
    always_comb begin
        sat = 1'b0;
        for (int i = DIGITS; i < NIB; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) sat = 1'b1;
        end
        disp_next = sat ? {DIGITS{4'd9}} : bcd_q[DIGITS*4-1:0];
    end

    // Double-dabble datapath, atomic display commit and frame blink counter.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            blink_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        bin_q <= score;
                        bcd_q <= '0;
                        cnt_q <= '0;
                    end
                end
                S_SHIFT: begin
                    bcd_q <= {bcd_adj[BW-2:0], bin_q[SCORE_W-1]};
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + 4'd1;
                end
                S_DONE: begin
                    disp_q  <= disp_next;
                    blink_q <= blink_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Stage 1 decode: which digit box the beam is in and the glyph cell inside it.
    always_comb begin
        left_k = '0;
        rel_x  = '0;
        hit_d  = 1'b0;
        dig_d  = '0;
        rel_y  = {1'b0, pixel_y} - {1'b0, y_pos};
        y_in   = ({1'b0, pixel_y} >= {1'b0, y_pos}) &&
                 ({1'b0, pixel_y} <  {1'b0, y_pos} + 11'(BOX_H));
        for (int k = 0; k < DIGITS; k++) begin
            left_k = {1'b0, x_pos} + 11'(k * PITCH);
            if (({1'b0, pixel_x} >= left_k) && ({1'b0, pixel_x} < left_k + 11'(BOX_W))) begin
                hit_d = y_in;
                dig_d = 2'(k);
                rel_x = {1'b0, pixel_x} - left_k;
            end
        end
        col_d = 2'(rel_x / 11'(SCALE));
        row_d = 3'(rel_y / 11'(SCALE));
    end

    // Stage 1 register.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            s1_in  <= 1'b0;
            s1_dig <= '0;
            s1_row <= '0;
            s1_col <= '0;
        end else begin
            s1_in  <= hit_d;
            s1_dig <= dig_d;
            s1_row <= row_d;
            s1_col <= col_d;
        end
    end

    // Stage 2 lookup: digit nibble, leading-zero blanking, glyph bit and blink gating.
    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        lz_run    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            lz_run = lz_run && (disp_q[(DIGITS-1-k)*4 +: 4] == 4'd0);
            if (s1_dig == 2'(k)) begin
                cur_nib   = disp_q[(DIGITS-1-k)*4 +: 4];
                cur_blank = (LZ_BLANK != 0) && lz_run && (k < DIGITS - 1);
            end
        end
        grow  = glyph_row(cur_nib, s1_row);
        pix_d = s1_in && !cur_blank && grow[2'd3 - s1_col] && !(blink_en && blink_q[5]);
    end

    // Stage 2 register drives the pixel output.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            pixel_on <= 1'b0;
        end else begin
            pixel_on <= pix_d;
        end
    end

endmodule

// File: tb/tb_score_renderer.sv
// tb/tb_score_renderer.sv - scoreboard bench for score_renderer
module tb_score_renderer;

    logic       clk_0 = 1'b0;
    logic       rst;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [6:0] score_a;
    logic [7:0] score_b;
    logic       frame_start;
    logic       blink_en;
    logic       pix_a;
    logic       busy_a;
    logic       pix_b;
    logic       busy_b;

    int n_tests = 0;
    int n_fail  = 0;
    int val_a;
    int val_b;
    int frames;
    int xpos_i;
    int ypos_i;

    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    int         pos_q[$];

    always #20 clk_0 = ~clk_0;

    score_renderer #(.DIGITS(2), .SCORE_W(7), .SCALE(8), .GAP(8), .LZ_BLANK(1)) dut_a (
        .clk_0(clk_0), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .x_pos(x_pos), .y_pos(y_pos), .score(score_a), .frame_start(frame_start),
        .blink_en(blink_en), .pixel_on(pix_a), .busy(busy_a)
    );

    score_renderer #(.DIGITS(2), .SCORE_W(8), .SCALE(8), .GAP(8), .LZ_BLANK(0)) dut_b (
        .clk_0(clk_0), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .x_pos(x_pos), .y_pos(y_pos), .score(score_b), .frame_start(frame_start),
        .blink_en(blink_en), .pixel_on(pix_b), .busy(busy_b)
    );

    function automatic logic [23:0] glyph(input int d);
        case (d)
            0: return 24'hF9999F;
            1: return 24'h111111;
            2: return 24'hF1F88F;
            3: return 24'hF1F11F;
            4: return 24'h99F111;
            5: return 24'hF8F11F;
            6: return 24'hF8F99F;
            7: return 24'hF11111;
            8: return 24'hF9F99F;
            9: return 24'hF9F111;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic bit blk();
        return blink_en && ((frames % 64) >= 32);
    endfunction

    function automatic bit model_pix(input int px, input int py, input int xp, input int yp,
                                     input int val, input bit lz, input bit blanked);
        int d[2];
        int rx;
        int ry;
        logic [23:0] g;
        if (blanked) return 1'b0;
        if (val > 99) begin
            d[0] = 9;
            d[1] = 9;
        end else begin
            d[0] = val / 10;
            d[1] = val % 10;
        end
        ry = py - yp;
        if (ry < 0 || ry >= 48) return 1'b0;
        for (int k = 0; k < 2; k++) begin
            rx = px - (xp + k * 40);
            if (rx >= 0 && rx < 32) begin
                if (lz && k == 0 && d[0] == 0) return 1'b0;
                g = glyph(d[k]);
                return g[23 - (ry / 8) * 4 - (rx / 8)];
            end
        end
        return 1'b0;
    endfunction

    task automatic set_origin(input int x, input int y);
        xpos_i = x;
        ypos_i = y;
        x_pos  = 10'(x);
        y_pos  = 10'(y);
    endtask

    task automatic scan(input int x0, input int x1, input int xs, input int y0, input int y1, input int ys);
        int tick = 0;
        for (int y = y0; y <= y1; y += ys) begin
            for (int x = x0; x <= x1; x += xs) begin
                @(negedge clk_0);
                if (tick >= 2) obs_q.push_back({pix_a, pix_b});
                tick++;
                pixel_x = 10'(x);
                pixel_y = 10'(y);
                exp_q.push_back({model_pix(x, y, xpos_i, ypos_i, val_a, 1'b1, blk()),
                                 model_pix(x, y, xpos_i, ypos_i, val_b, 1'b0, blk())});
                pos_q.push_back(x * 1024 + y);
            end
        end
        repeat (2) begin
            @(negedge clk_0);
            if (tick >= 2) obs_q.push_back({pix_a, pix_b});
            tick++;
        end
    endtask

    task automatic convert(input int v, output int cyc_a, output int cyc_b);
        @(negedge clk_0);
        score_a     = 7'(v);
        score_b     = 8'(v);
        frame_start = 1'b1;
        @(negedge clk_0);
        frame_start = 1'b0;
        cyc_a = 0;
        cyc_b = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a) cyc_a++;
            if (busy_b) cyc_b++;
            if (i > 0 && !busy_a && !busy_b) break;
            @(negedge clk_0);
        end
        val_a  = v & 127;
        val_b  = v & 255;
        frames = frames + 1;
    endtask

    task automatic test_reset;
        int p;
        logic [1:0] e;
        logic [1:0] o;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk_0);
            pixel_x = 10'd140;
            pixel_y = 10'd20;
            n_tests++;
            if ({pix_a, pix_b, busy_a, busy_b} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs: pix/busy a,b=%b required 0000", {pix_a, pix_b, busy_a, busy_b});
            end
        end
        rst    = 1'b1;
        val_a  = 0;
        val_b  = 0;
        frames = 0;
        scan(96, 175, 1, 16, 71, 2);
        while (exp_q.size() > 0) begin
            p = pos_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_scan (%0d,%0d): pixel_on a,b=%b required %b", p / 1024, p % 1024, o, e);
            end
        end
    endtask

    task automatic test_convert;
        int ca, cb, p;
        logic [1:0] e;
        logic [1:0] o;
        convert(42, ca, cb);
        n_tests++;
        if (ca !== 8 || cb !== 9) begin
            n_fail++;
            $display("FAIL convert_busy_len: a=%0d b=%0d required 8 9", ca, cb);
        end
        scan(96, 175, 1, 16, 71, 2);
        while (exp_q.size() > 0) begin
            p = pos_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL convert_scan (%0d,%0d): pixel_on a,b=%b required %b", p / 1024, p % 1024, o, e);
            end
        end
    endtask

    task automatic test_lz;
        int ca, cb, p;
        logic [1:0] e;
        logic [1:0] o;
        convert(7, ca, cb);
        n_tests++;
        if (ca !== 8 || cb !== 9) begin
            n_fail++;
            $display("FAIL lz_busy_len: a=%0d b=%0d required 8 9", ca, cb);
        end
        scan(96, 175, 1, 16, 71, 2);
        while (exp_q.size() > 0) begin
            p = pos_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL lz_scan (%0d,%0d): pixel_on a,b=%b required %b", p / 1024, p % 1024, o, e);
            end
        end
    endtask

    task automatic test_mid_conv;
        int ca, p;
        bit stray;
        logic [1:0] e;
        logic [1:0] o;
        logic [1:0] old_e;
        old_e = {model_pix(100, 36, xpos_i, ypos_i, val_a, 1'b1, blk()),
                 model_pix(100, 36, xpos_i, ypos_i, val_b, 1'b0, blk())};
        @(negedge clk_0);
        pixel_x = 10'd100; pixel_y = 10'd36;
        score_a = 7'd42; score_b = 8'd42; frame_start = 1'b1;
        ca = 0;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk_0);
            frame_start = (i == 3);
            if (i == 3) begin score_a = 7'd99; score_b = 8'd99; end
            if (i == 4) begin score_a = 7'd13; score_b = 8'd13; end
            if (busy_a) ca++;
            if (i >= 2 && busy_a) begin
                n_tests++;
                if ({pix_a, pix_b} !== old_e) begin
                    n_fail++;
                    $display("FAIL mid_conv_old_shown cycle %0d: pixel_on a,b=%b required %b", i, {pix_a, pix_b}, old_e);
                end
            end
            if (i > 1 && !busy_a && !busy_b) break;
        end
        val_a = 42; val_b = 42; frames = frames + 1;
        n_tests++;
        if (ca !== 8) begin
            n_fail++;
            $display("FAIL mid_conv_busy_len: a=%0d required 8", ca);
        end
        stray = 1'b0;
        repeat (12) begin
            @(negedge clk_0);
            if (busy_a || busy_b) stray = 1'b1;
        end
        n_tests++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_conv_second_pulse: busy reasserted=%b required 0", stray);
        end
        scan(96, 175, 1, 16, 71, 2);
        while (exp_q.size() > 0) begin
            p = pos_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mid_conv_scan (%0d,%0d): pixel_on a,b=%b required %b", p / 1024, p % 1024, o, e);
            end
        end
    endtask

    task automatic test_saturate;
        int ca, cb, p;
        int vals[3] = '{150, 99, 100};
        logic [1:0] e;
        logic [1:0] o;
        foreach (vals[j]) begin
            convert(vals[j], ca, cb);
            n_tests++;
            if (ca !== 8 || cb !== 9) begin
                n_fail++;
                $display("FAIL sat_busy_len score %0d: a=%0d b=%0d required 8 9", vals[j], ca, cb);
            end
            scan(96, 175, 2, 16, 71, 4);
            while (exp_q.size() > 0) begin
                p = pos_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL sat_scan score %0d (%0d,%0d): pixel_on a,b=%b required %b",
                             vals[j], p / 1024, p % 1024, o, e);
                end
            end
        end
    endtask

    task automatic test_edge_pos;
        int p;
        logic [1:0] e;
        logic [1:0] o;
        set_origin(1000, 1000);
        scan(984, 1023, 1, 992, 1023, 1);
        scan(0, 60, 1, 0, 30, 3);
        while (exp_q.size() > 0) begin
            p = pos_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL edge_scan (%0d,%0d): pixel_on a,b=%b required %b", p / 1024, p % 1024, o, e);
            end
        end
        set_origin(100, 20);
    endtask

    task automatic test_reset_mid;
        int p;
        logic [1:0] e;
        logic [1:0] o;
        @(negedge clk_0);
        score_a = 7'd42; score_b = 8'd42; frame_start = 1'b1;
        @(negedge clk_0);
        frame_start = 1'b0;
        @(negedge clk_0);
        @(negedge clk_0);
        rst = 1'b0;
        @(negedge clk_0);
        n_tests++;
        if ({busy_a, busy_b, pix_a, pix_b} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy/pix a,b=%b required 0000", {busy_a, busy_b, pix_a, pix_b});
        end
        rst = 1'b1;
        val_a = 0; val_b = 0; frames = 0;
        scan(96, 175, 1, 16, 71, 2);
        while (exp_q.size() > 0) begin
            p = pos_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_scan (%0d,%0d): pixel_on a,b=%b required %b", p / 1024, p % 1024, o, e);
            end
        end
    endtask

    task automatic test_blink;
        int ca, cb, p;
        logic [1:0] e;
        logic [1:0] o;
        blink_en = 1'b1;
        for (int f = 0; f < 64; f++) begin
            convert(42, ca, cb);
            n_tests++;
            if (ca !== 8 || cb !== 9) begin
                n_fail++;
                $display("FAIL blink_busy_len frame %0d: a=%0d b=%0d required 8 9", f, ca, cb);
            end
            scan(100, 100, 1, 36, 36, 1);
            scan(148, 148, 1, 36, 36, 1);
        end
        while (exp_q.size() > 0) begin
            p = pos_q.pop_front(); e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL blink_pixel (%0d,%0d): pixel_on a,b=%b required %b", p / 1024, p % 1024, o, e);
            end
        end
        blink_en = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        score_a     = '0;
        score_b     = '0;
        frame_start = 1'b0;
        blink_en    = 1'b0;
        val_a       = 0;
        val_b       = 0;
        frames      = 0;
        set_origin(100, 20);
        test_reset;
        test_convert;
        test_lz;
        test_mid_conv;
        test_saturate;
        test_edge_pos;
        test_reset_mid;
        test_blink;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
